// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory master.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS = 16;
  localparam int unsigned SPI_ADDR_BITS  = 7;
  localparam int unsigned SPI_DATA_BITS  = 8;
  localparam int unsigned SPI_IDX_BITS   = 4;
  localparam int unsigned SPI_CNT_BITS   = 8;
  localparam logic        SPI_RW_READ    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD,
    GAP
  } spi_state_e;

  // Build the outgoing frame: address, rw flag, then data (zeros on reads).
  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
    input logic [SPI_ADDR_BITS-1:0] addr,
    input logic                     rw,
    input logic [SPI_DATA_BITS-1:0] wdata
  );
    logic [SPI_DATA_BITS-1:0] data;
    data = (rw == SPI_RW_READ) ? '0 : wdata;
    return {addr, rw, data};
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Phase down-counter: reloads to CLKDIV-1 and flags the last cycle of each phase.
module spi_phase_timer
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic phase_end
);

  localparam logic [SPI_CNT_BITS-1:0] RELOAD = SPI_CNT_BITS'(CLKDIV - 1);

  logic [SPI_CNT_BITS-1:0] count_q, count_d;
  logic                    phase_end_q, phase_end_d;

  // Next count; phase_end is registered so it is high exactly while count is 0.
  always_comb begin
    count_d     = count_q;
    phase_end_d = 1'b0;
    if (load) begin
      count_d = RELOAD;
    end else if (run) begin
      count_d     = (count_q == '0) ? RELOAD : count_q - SPI_CNT_BITS'(1);
      phase_end_d = (count_d == '0);
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      phase_end_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      phase_end_q <= phase_end_d;
    end
  end

  assign phase_end = phase_end_q;

endmodule

// File: rtl/spi_memory_master.sv
// SPI mode-0 initiator issuing single-byte read/write frames to the SPI memory slave.
module spi_memory_master
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam logic [SPI_IDX_BITS-1:0] LAST_IDX       = SPI_IDX_BITS'(SPI_FRAME_BITS - 1);
  localparam logic [SPI_IDX_BITS-1:0] FIRST_DATA_IDX = SPI_IDX_BITS'(SPI_FRAME_BITS - SPI_DATA_BITS);

  spi_state_e                state_q, state_d;
  logic [SPI_FRAME_BITS-1:0] tx_q, tx_d;
  logic [SPI_DATA_BITS-1:0]  rx_q, rx_d;
  logic [SPI_DATA_BITS-1:0]  rdata_q, rdata_d;
  logic [SPI_IDX_BITS-1:0]   bit_idx_q, bit_idx_d;
  logic                      rw_q, rw_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      sclk_q, sclk_d;
  logic                      cs_q, cs_d;
  logic                      mosi_q, mosi_d;
  logic                      timer_load_c;
  logic                      timer_run_c;
  logic                      phase_end;

  assign timer_run_c = (state_q != IDLE);

  spi_phase_timer #(
    .CLKDIV(CLKDIV)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load_c),
    .run      (timer_run_c),
    .phase_end(phase_end)
  );

  // Frame sequencing: next state, shift registers and pin values.
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rdata_d      = rdata_q;
    bit_idx_d    = bit_idx_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    sclk_d       = sclk_q;
    cs_d         = cs_q;
    mosi_d       = mosi_q;
    timer_load_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOW;
          rw_d         = rw;
          tx_d         = spi_frame(addr, rw, wdata);
          bit_idx_d    = '0;
          mosi_d       = addr[SPI_ADDR_BITS-1];
          cs_d         = 1'b0;
          busy_d       = 1'b1;
          timer_load_c = 1'b1;
        end
      end
      LOW: begin
        if (phase_end) begin
          if ((bit_idx_q >= FIRST_DATA_IDX) && (rw_q == SPI_RW_READ)) begin
            rx_d = {rx_q[SPI_DATA_BITS-2:0], miso_pin};
          end
          state_d = HIGH;
          sclk_d  = 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          if (bit_idx_q == LAST_IDX) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            state_d   = LOW;
            bit_idx_d = bit_idx_q + SPI_IDX_BITS'(1);
            tx_d      = {tx_q[SPI_FRAME_BITS-2:0], 1'b0};
            mosi_d    = tx_q[SPI_FRAME_BITS-2];
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          state_d = GAP;
          done_d  = 1'b1;
          cs_d    = 1'b1;
          if (rw_q == SPI_RW_READ) begin
            rdata_d = rx_q;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      bit_idx_q <= '0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      bit_idx_q <= bit_idx_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = mosi_q;

endmodule
